// File: rtl/lfsr_word_harvester.sv
// lfsr_word_harvester
//
// Harvests non-overlapping words from a free-running Fibonacci LFSR whitener.
// It counts LFSR shifts and snapshots the LFSR register once WIDTH fresh shifts
// have accumulated, so no two delivered words share bits. After reset it
// discards WARMUP_WORDS captured words. It then queues the words in a small
// FIFO and hands them to a consumer over a valid/ready handshake.
//
// Optional feature, enabled by defining LFSR_HARVESTER_XOR_FOLD_EN:
//   In RUN, captures alternate. An odd capture loads a fold register and
//   does not push. An even capture pushes (fold ^ lfsr_state). This halves
//   the word rate.
//   The fold phase restarts at "odd" on reset and on entry to RUN.
//   Without the macro, every RUN capture pushes lfsr_state unmodified.
//
// Ports:
//   CLK            in   sole clock
//   reset_n        in   asynchronous active-low reset
//   shift_en       in   LFSR shifts at the end of this cycle
//   lfsr_state     in   LFSR register; bit 0 maps to word_out[WIDTH-1]
//   word_out       out  FIFO head word (holds its last value while empty)
//   word_valid     out  FIFO non-empty
//   word_ready     in   consumer takes word_out on valid && ready
//   level          out  FIFO occupancy, 0..DEPTH
//   overflow       out  sticky: a word was dropped because the FIFO was full
//   clear_overflow in   synchronous clear of overflow
module lfsr_word_harvester #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int WARMUP_WORDS = 4
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       shift_en,
    input  logic [WIDTH-1:0]           lfsr_state,
    output logic [WIDTH-1:0]           word_out,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clear_overflow
);

    localparam int CNT_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int LVL_W       = PTR_W + 1;
    localparam int WARM_W      = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;
    localparam int WARM_LAST_I = (WARMUP_WORDS > 0) ? WARMUP_WORDS - 1 : 0;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic               capture_pending_q, capture_pending_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   head_q, head_d;
    logic               overflow_q, overflow_d;
    logic [WIDTH-1:0]   mem [DEPTH];

`ifdef LFSR_HARVESTER_XOR_FOLD_EN
    logic [WIDTH-1:0]   fold_q, fold_d;
    logic               fold_phase_q, fold_phase_d;   // 0: next RUN capture loads fold
`endif

    logic               push_req;
    logic [WIDTH-1:0]   push_raw;
    logic [WIDTH-1:0]   push_word;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic               drop;
    logic [PTR_W-1:0]   rd_next;

    // LFSR bit 0 lands in the word MSB. The reversal is applied after any fold,
    // which is equivalent because XOR works bitwise.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign push_word[gi] = push_raw[WIDTH-1-gi];
    end

    assign pop     = (count_q != '0) && word_ready;
    assign full    = (count_q == LVL_W'(DEPTH));
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d           = state_q;
        shift_cnt_d       = shift_cnt_q;
        warm_cnt_d        = warm_cnt_q;
        push_req          = 1'b0;
        push_raw          = lfsr_state;
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
        fold_d            = fold_q;
        fold_phase_d      = fold_phase_q;
`endif

        // A capture is armed only by the WIDTH-th shift. It lasts exactly one
        // cycle, so counting never pauses for it.
        capture_pending_d = shift_en && (shift_cnt_q == CNT_W'(WIDTH - 1));
        if (shift_en) begin
            shift_cnt_d = (shift_cnt_q == CNT_W'(WIDTH - 1)) ? '0 : shift_cnt_q + CNT_W'(1);
        end

        if (capture_pending_q) begin
            case (state_q)
                ST_WARMUP: begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    if (warm_cnt_q == WARM_W'(WARM_LAST_I)) begin
                        state_d = ST_RUN;
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
                        fold_phase_d = 1'b0;
`endif
                    end
                end
                default: begin
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
                    if (!fold_phase_q) begin
                        fold_d       = lfsr_state;
                        fold_phase_d = 1'b1;
                    end else begin
                        push_req     = 1'b1;
                        push_raw     = fold_q ^ lfsr_state;
                        fold_phase_d = 1'b0;
                    end
`else
                    push_req = 1'b1;
`endif
                end
            endcase
        end

        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + LVL_W'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - LVL_W'(1);
        end

        // The head is a separate register, so word_out stays stable while the
        // FIFO is empty. After a pop it takes the next stored entry. If the
        // FIFO is draining to empty, it takes the incoming word instead.
        head_d = head_q;
        if (count_q == '0) begin
            if (push_ok) begin
                head_d = push_word;
            end
        end else if (pop) begin
            if (count_q == LVL_W'(1)) begin
                if (push_ok) begin
                    head_d = push_word;
                end
            end else begin
                head_d = mem[rd_next];
            end
        end

        // A drop on the same edge as a clear wins, so no loss goes unreported.
        overflow_d = (overflow_q && !clear_overflow) || drop;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= (WARMUP_WORDS == 0) ? ST_RUN : ST_WARMUP;
            shift_cnt_q       <= '0;
            capture_pending_q <= 1'b0;
            warm_cnt_q        <= '0;
            rd_ptr_q          <= '0;
            wr_ptr_q          <= '0;
            count_q           <= '0;
            head_q            <= '0;
            overflow_q        <= 1'b0;
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
            fold_q            <= '0;
            fold_phase_q      <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            shift_cnt_q       <= shift_cnt_d;
            capture_pending_q <= capture_pending_d;
            warm_cnt_q        <= warm_cnt_d;
            rd_ptr_q          <= rd_ptr_d;
            wr_ptr_q          <= wr_ptr_d;
            count_q           <= count_d;
            head_q            <= head_d;
            overflow_q        <= overflow_d;
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
            fold_q            <= fold_d;
            fold_phase_q      <= fold_phase_d;
`endif
        end
    end

    // The storage array needs no reset. The pointers and count define which
    // entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign word_out   = head_q;
    assign word_valid = (count_q != '0);
    assign level      = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_lfsr_word_harvester.sv
// Testbench for lfsr_word_harvester (default parameters: WIDTH 16, DEPTH 4,
// WARMUP_WORDS 4). The reference model tracks the total shifts since reset,
// the number of captures, and a queue of delivered words. It checks every
// output after every clock edge and after every asynchronous reset.
module tb_lfsr_word_harvester;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              shift_en;
    logic [WIDTH-1:0]  lfsr_state;
    logic [WIDTH-1:0]  word_out;
    logic              word_valid;
    logic              word_ready;
    logic [2:0]        level;
    logic              overflow;
    logic              clear_overflow;

    always #5 clk = ~clk;

    lfsr_word_harvester #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .WARMUP_WORDS (WARMUP)
    ) dut (
        .CLK            (clk),
        .reset_n        (reset_n),
        .shift_en       (shift_en),
        .lfsr_state     (lfsr_state),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint            m_shifts;
    bit                m_pending;
    int                m_caps;
    int                m_run_caps;
    logic [WIDTH-1:0]  m_fold;
    logic [WIDTH-1:0]  m_q[$];
    logic [WIDTH-1:0]  m_head;
    bit                m_ovf;

    function automatic logic [WIDTH-1:0] rev_bits(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    task automatic model_reset();
        m_shifts   = 0;
        m_pending  = 0;
        m_caps     = 0;
        m_run_caps = 0;
        m_fold     = '0;
        m_q.delete();
        m_head     = '0;
        m_ovf      = 0;
    endtask

    // Applies one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit               pop;
        bit               cap;
        bit               drop;
        bit               want_push;
        logic [WIDTH-1:0] word;
        pop       = (m_q.size() > 0) && word_ready;
        cap       = m_pending;
        drop      = 0;
        want_push = 0;
        word      = rev_bits(lfsr_state);
        // The 16th, 32nd, ... shift since reset arms a capture for the next edge.
        m_pending = shift_en && ((m_shifts % WIDTH) == WIDTH - 1);
        if (shift_en) m_shifts++;
        if (pop) void'(m_q.pop_front());
        if (cap) begin
            m_caps++;
            if (m_caps > WARMUP) begin
`ifdef LFSR_HARVESTER_XOR_FOLD_EN
                m_run_caps++;
                if (m_run_caps % 2 == 1) begin
                    m_fold = lfsr_state;
                end else begin
                    want_push = 1;
                    word      = rev_bits(m_fold ^ lfsr_state);
                end
`else
                want_push = 1;
`endif
            end
        end
        if (want_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(word);
            else drop = 1;
        end
        m_ovf = (m_ovf && !clear_overflow) || drop;
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic check_outputs();
        check_value("word_valid", word_valid, m_q.size() > 0);
        check_value("level",      level,      m_q.size());
        check_value("word_out",   word_out,   m_head);
        check_value("overflow",   overflow,   m_ovf);
    endtask

    // One cycle: inputs change on the falling edge, and checks run 1 time
    // unit after the rising edge. With rst set, reset_n drops at the falling
    // edge and the outputs must clear at once.
    task automatic do_cycle(input bit se, input bit rdy, input bit clr, input bit rst);
        @(negedge clk);
        shift_en       = se;
        word_ready     = rdy;
        clear_overflow = clr;
        lfsr_state     = WIDTH'($urandom);
        if (rst) begin
            reset_n = 1'b0;
            #1;
            model_reset();
            check_outputs();
            @(posedge clk);
            #1;
            check_outputs();
        end else begin
            reset_n = 1'b1;
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    initial begin
        int bias;
        reset_n        = 1'b0;
        shift_en       = 1'b0;
        word_ready     = 1'b0;
        clear_overflow = 1'b0;
        lfsr_state     = '0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();

        // Warm-up with continuous shifting and an always-ready consumer.
        for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        // Consumer stalls: the FIFO fills and further words are dropped.
        for (int i = 0; i < 130; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        // Sparse pops against a full FIFO, including pops on capture edges.
        for (int i = 0; i < 60; i++)  do_cycle(1'b1, ($urandom % 8) == 0, 1'b0, 1'b0);
        // Fill again and hold clear_overflow high while drops continue.
        for (int i = 0; i < 80; i++)  do_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)  do_cycle(1'b1, 1'b1, 1'b1, 1'b0);

        // Reset mid-word with two queued words (shift counter at 9, level 2).
        do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 105; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 120; i++) do_cycle(1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized mix with per-block ready bias and occasional resets.
        for (int blk = 0; blk < 16; blk++) begin
            bias = $urandom_range(0, 8);
            for (int i = 0; i < 200; i++) begin
                do_cycle(($urandom % 4) != 0,
                         ($urandom % 8) < bias,
                         ($urandom % 16) == 0,
                         ($urandom % 500) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
